serial_word_feeder: RTL and testbench

- Parallel-to-serial front end for the bit-serial two's-complement stage.
- Accepts WIDTH-bit words on a valid/ready handshake and shifts each word out LSB first, one bit per clock.
- Drives a word-start strobe on the first bit of each word, which the downstream stage uses as its per-word reset.
- A one-word holding register lets consecutive words stream with no idle cycle between them.

---
 rtl/serial_word_feeder.sv | 94 +++++++++
 tb/tb_serial_word_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end: takes WIDTH-bit words on valid/ready and shifts them
// out LSB first, with a word-start strobe and a one-word holding register for gapless streaming.
module serial_word_feeder #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_first,
    output logic             ser_last,
    output logic             ser_active
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic accept;
    logic transfer;
    logic active;

    assign in_ready = !hold_full_q;
    assign accept   = in_valid && in_ready;
    // The held word moves into the shifter either immediately (idle) or right after the last bit.
    assign transfer = hold_full_q && (state_q == IDLE || cnt_q == LAST);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;

        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        if (transfer) begin
            // accept and transfer are mutually exclusive: transfer needs hold_full, accept needs it clear.
            sh_d        = hold_q;
            cnt_d       = '0;
            state_d     = SHIFT;
            hold_full_d = 1'b0;
        end else if (state_q == SHIFT) begin
            sh_d = sh_q >> 1;
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so a word cut off by reset can never leak out later.
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
        end
    end

    assign active     = (state_q == SHIFT);
    assign ser_active = active;
    assign ser_bit    = active && sh_q[0];
    assign ser_first  = active && (cnt_q == '0);
    assign ser_last   = active && (cnt_q == LAST);

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder: the driver predicts each bit and its cycle from
// accept times; a negedge monitor compares, and a behavioural serial negator checks the chain.
module tb_serial_word_feeder;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, ser_bit, ser_first, ser_last, ser_active;

    logic [1:0] in_data2;
    logic       in_valid2;
    logic       in_ready2, ser_bit2, ser_first2, ser_last2, ser_active2;

    serial_word_feeder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_bit(ser_bit), .ser_first(ser_first), .ser_last(ser_last), .ser_active(ser_active)
    );

    serial_word_feeder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .ser_bit(ser_bit2), .ser_first(ser_first2), .ser_last(ser_last2), .ser_active(ser_active2)
    );

    typedef struct {
        logic       b;
        logic       f;
        logic       l;
        int         cyc;
        logic [7:0] word;
        int         idx;
    } exp_t;

    typedef struct {
        logic b;
        logic f;
        logic l;
        int   cyc;
    } obs_t;

    exp_t sb[$];
    int   pend[$];
    obs_t obs2[$];
    int   cyc;
    int   last_end;
    int   n_checks;
    int   n_pass;

    exp_t       mon_e;
    logic       mon_exp_act;
    logic       neg_seen;
    logic       neg_bit;
    logic [7:0] neg_acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Predict the cycles of a word from its accept edge: it starts after the accept and after the previous word.
    task automatic issue(input logic [7:0] d);
        int n;
        int s;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        s = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
        last_end = s + 7;
        pend.push_back(s);
        for (int i = 0; i < 8; i++)
            sb.push_back('{b: d[i], f: (i == 0), l: (i == 7), cyc: s + i, word: d, idx: i});
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_outs", 32'({ser_bit, ser_first, ser_last, ser_active}), 32'd0);
            check("rst_ready", 32'(in_ready), 32'd1);
        end else begin
            while (pend.size() != 0 && pend[0] <= cyc) void'(pend.pop_front());
            check("in_ready", 32'(in_ready), 32'(pend.size() == 0));
            mon_exp_act = (sb.size() != 0) && (sb[0].cyc == cyc);
            check("active", 32'(ser_active), 32'(mon_exp_act));
            if (mon_exp_act) begin
                mon_e = sb.pop_front();
                check("bit", 32'(ser_bit), 32'(mon_e.b));
                check("first", 32'(ser_first), 32'(mon_e.f));
                check("last", 32'(ser_last), 32'(mon_e.l));
                // Downstream serial negator: copy bits up to the first 1, invert the rest.
                if (ser_first) begin
                    neg_seen = 1'b0;
                    neg_acc  = '0;
                end
                neg_bit = neg_seen ? ~ser_bit : ser_bit;
                neg_seen = neg_seen | ser_bit;
                neg_acc[mon_e.idx[2:0]] = neg_bit;
                if (mon_e.l) check("chain_neg", 32'(neg_acc), 32'(8'(~mon_e.word + 8'd1)));
            end else begin
                check("idle_outs", 32'({ser_bit, ser_first, ser_last}), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ser_active2)
            obs2.push_back('{b: ser_bit2, f: ser_first2, l: ser_last2, cyc: cyc});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_b2;
        logic [3:0] exp_f2;
        logic [3:0] exp_l2;
        int         n;
        int         lim;

        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        last_end  = -1;
        neg_seen  = 1'b0;
        neg_acc   = '0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_data2  = '0;
        in_valid2 = 1'b0;

        repeat (2) @(posedge clk);
        #3;
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_outs", 32'({ser_bit, ser_first, ser_last, ser_active}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // WIDTH=2: 2'b10 then 2'b01 back-to-back.
        in_data2  = 2'b10;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_data2 = 2'b01;
        n = 0;
        while (!in_ready2 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        exp_b2 = 4'b0110;
        exp_f2 = 4'b0101;
        exp_l2 = 4'b1010;
        check("w2_count", 32'(obs2.size()), 32'd4);
        lim = (obs2.size() < 4) ? obs2.size() : 4;
        for (int i = 0; i < lim; i++) begin
            check("w2_bit", 32'(obs2[i].b), 32'(exp_b2[i]));
            check("w2_first", 32'(obs2[i].f), 32'(exp_f2[i]));
            check("w2_last", 32'(obs2[i].l), 32'(exp_l2[i]));
            check("w2_contig", 32'(obs2[i].cyc - obs2[0].cyc), 32'(i));
        end

        // Single word, then idle.
        issue(8'h35);
        drain();

        // Back-to-back and backpressure.
        issue(8'h01);
        issue(8'h80);
        drain();
        issue(8'hAA);
        issue(8'h55);
        issue(8'hF0);
        drain();

        // Chain check.
        issue(8'h06);
        drain();

        // Asynchronous reset during bit 3 of 8'hFF.
        issue(8'hFF);
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_active", 32'(ser_active), 32'd1);
        #1;
        rst_n = 1'b0;
        sb.delete();
        pend.delete();
        last_end = cyc;
        #1;
        check("async_rst_outs", 32'({ser_bit, ser_first, ser_last, ser_active}), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_end = cyc;
        issue(8'h0F);
        drain();

        // Random words with random gaps (zero gap streams back-to-back).
        for (int k = 0; k < 40; k++) begin
            issue(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
